// File: rtl/lcd_id_probe_pkg.sv
// ---------------------------------------------------------------------------
// lcd_id_pkg
// Shared types and constants for the LCD panel ID probe:
//   - probe_state_e : probe sequencer states
//   - LCD_ID_*      : panel ID codes carried on the strap bits
//   - RES_*         : panel resolutions in pixels
//   - ID_OUT_W / RES_W : widths of the id and resolution outputs
// ---------------------------------------------------------------------------
package lcd_id_pkg;

  localparam int ID_OUT_W = 8;
  localparam int RES_W    = 11;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } probe_state_e;

  // Panel ID codes (low three strap bits).
  localparam logic [2:0] LCD_ID_43_480  = 3'd0;
  localparam logic [2:0] LCD_ID_7_800   = 3'd1;
  localparam logic [2:0] LCD_ID_7_1024  = 3'd2;
  localparam logic [2:0] LCD_ID_43_800  = 3'd4;
  localparam logic [2:0] LCD_ID_10_1280 = 3'd5;

  // Panel resolutions.
  localparam logic [RES_W-1:0] RES_H_480  = 11'd480;
  localparam logic [RES_W-1:0] RES_H_800  = 11'd800;
  localparam logic [RES_W-1:0] RES_H_1024 = 11'd1024;
  localparam logic [RES_W-1:0] RES_H_1280 = 11'd1280;
  localparam logic [RES_W-1:0] RES_V_272  = 11'd272;
  localparam logic [RES_W-1:0] RES_V_480  = 11'd480;
  localparam logic [RES_W-1:0] RES_V_600  = 11'd600;
  localparam logic [RES_W-1:0] RES_V_800  = 11'd800;
  localparam logic [RES_W-1:0] RES_NONE   = 11'd0;

endpackage

// File: rtl/lcd_id_probe_if.sv
// ---------------------------------------------------------------------------
// lcd_id_probe_if
// Bundle between the LCD pad ring / timing controller and the ID probe.
//   lcd_rgb  : RGB bus pad input (DATA_W bits)
//   rd_req   : single-cycle re-probe request
//   rgb_oe   : controller may drive the RGB bus
//   id       : latched panel ID, zero-extended to 8 bits
//   id_valid : id is stable and valid
//   id_err   : no stable ID found before the timeout
//   h_res    : decoded horizontal resolution (0 when unknown/absent)
//   v_res    : decoded vertical resolution (0 when unknown/absent)
// Modports: master = the probe itself, slave = the surrounding logic.
// ---------------------------------------------------------------------------
interface lcd_id_probe_if
  import lcd_id_pkg::*;
#(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0]   lcd_rgb;
  logic                rd_req;
  logic                rgb_oe;
  logic [ID_OUT_W-1:0] id;
  logic                id_valid;
  logic                id_err;
  logic [RES_W-1:0]    h_res;
  logic [RES_W-1:0]    v_res;

  modport master (
    input  lcd_rgb,
    input  rd_req,
    output rgb_oe,
    output id,
    output id_valid,
    output id_err,
    output h_res,
    output v_res
  );

  modport slave (
    output lcd_rgb,
    output rd_req,
    input  rgb_oe,
    input  id,
    input  id_valid,
    input  id_err,
    input  h_res,
    input  v_res
  );

endinterface

// File: rtl/lcd_id_probe_decode.sv
// ---------------------------------------------------------------------------
// lcd_id_decode
// Combinational panel ID -> resolution table. Only instantiated when the
// probe is built with LCD_ID_DECODE_EN defined.
//   code  : low three bits of the panel ID
//   h_res : horizontal pixels, 0 for unknown codes
//   v_res : vertical pixels, 0 for unknown codes
// ---------------------------------------------------------------------------
module lcd_id_decode
  import lcd_id_pkg::*;
(
  input  logic [2:0]       code,
  output logic [RES_W-1:0] h_res,
  output logic [RES_W-1:0] v_res
);

  // ID code lookup; codes without a known panel decode to 0x0.
  always_comb begin
    h_res = RES_NONE;
    v_res = RES_NONE;
    case (code)
      LCD_ID_43_480: begin
        h_res = RES_H_480;
        v_res = RES_V_272;
      end
      LCD_ID_7_800: begin
        h_res = RES_H_800;
        v_res = RES_V_480;
      end
      LCD_ID_7_1024: begin
        h_res = RES_H_1024;
        v_res = RES_V_600;
      end
      LCD_ID_43_800: begin
        h_res = RES_H_800;
        v_res = RES_V_480;
      end
      LCD_ID_10_1280: begin
        h_res = RES_H_1280;
        v_res = RES_V_800;
      end
      default: begin
        h_res = RES_NONE;
        v_res = RES_NONE;
      end
    endcase
  end

endmodule

// File: rtl/lcd_id_probe.sv
// ---------------------------------------------------------------------------
// lcd_id_probe
// Reads the panel ID strap bits off the tri-stated RGB bus after reset:
// waits SETTLE_CYC cycles, then requires SAMPLES consecutive identical
// strap readings within TIMEOUT_CYC sample cycles. On success the ID is
// latched and id_valid/rgb_oe rise; on timeout id_err/rgb_oe rise. A
// rd_req pulse in DONE or ERROR restarts the whole probe.
//
// Ports:
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : lcd_id_probe_if.master (lcd_rgb, rd_req in; rgb_oe, id,
//         id_valid, id_err, h_res, v_res out)
//
// Build option: define LCD_ID_DECODE_EN to load h_res/v_res from the ID
// on the latch edge; otherwise both are tied to 0.
// ---------------------------------------------------------------------------
module lcd_id_probe
  import lcd_id_pkg::*;
#(
  parameter int                      DATA_W      = 16,
  parameter int                      ID_W        = 3,
  parameter int                      POS_W       = $clog2(DATA_W),
  // Slice k (LSB first) is the lcd_rgb bit index feeding id[k].
  parameter logic [ID_W*POS_W-1:0]   STRAP_POS   = {4'd4, 4'd10, 4'd15},
  parameter int                      SETTLE_CYC  = 16,
  parameter int                      SAMPLES     = 8,
  parameter int                      TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  lcd_id_probe_if.master   bus
);

  localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int STAB_W = $clog2(SAMPLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_ZERO   = STAB_W'(0);
  localparam logic [STAB_W-1:0] STAB_ONE    = STAB_W'(1);
  localparam logic [STAB_W-1:0] SAMPLES_V   = STAB_W'(SAMPLES);
  localparam logic [TMO_W-1:0]  TMO_ZERO    = TMO_W'(0);
  localparam logic [TMO_W-1:0]  TMO_ONE     = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TIMEOUT_V   = TMO_W'(TIMEOUT_CYC);
  localparam logic [ID_W-1:0]   CAND_ZERO   = ID_W'(0);
  localparam logic [ID_OUT_W-1:0] ID_ZERO   = 8'h00;

  probe_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic [TMO_W-1:0]    tmo_r, tmo_nx_s;
  logic [STAB_W-1:0]   stab_r, stab_nx_s;
  logic [ID_W-1:0]     prev_r, prev_nx_s;
  logic [ID_OUT_W-1:0] id_r, id_nx_s;
  logic                id_valid_r, id_valid_nx_s;
  logic                id_err_r, id_err_nx_s;
  logic                rgb_oe_r, rgb_oe_nx_s;

  logic [ID_W-1:0]     cand_s;
  logic [ID_OUT_W-1:0] cand_ext_s;

  // Candidate ID: a pure combinational pick of the strap bits.
  for (genvar k = 0; k < ID_W; k++) begin : g_cand
    assign cand_s[k] = bus.lcd_rgb[STRAP_POS[k*POS_W +: POS_W]];
  end

  // Zero-extend the candidate to the 8-bit id width.
  always_comb begin
    cand_ext_s             = ID_ZERO;
    cand_ext_s[ID_W-1:0]   = cand_s;
  end

  // Next-state and next-output logic of the probe sequencer.
  always_comb begin
    state_nx_s    = state_r;
    cnt_nx_s      = cnt_r;
    tmo_nx_s      = tmo_r;
    stab_nx_s     = stab_r;
    prev_nx_s     = prev_r;
    id_nx_s       = id_r;
    id_valid_nx_s = id_valid_r;
    id_err_nx_s   = id_err_r;
    rgb_oe_nx_s   = rgb_oe_r;
    case (state_r)
      SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = SAMPLE;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end
      SAMPLE: begin
        prev_nx_s = cand_s;
        tmo_nx_s  = tmo_r + TMO_ONE;
        // stab==0 marks the first sample, which has no valid prev to match.
        if ((cand_s == prev_r) && (stab_r != STAB_ZERO)) begin
          stab_nx_s = stab_r + STAB_ONE;
        end else begin
          stab_nx_s = STAB_ONE;
        end
        // Success is tested first so it wins over a coincident timeout.
        if (stab_nx_s == SAMPLES_V) begin
          id_nx_s       = cand_ext_s;
          id_valid_nx_s = 1'b1;
          rgb_oe_nx_s   = 1'b1;
          state_nx_s    = DONE;
        end else if (tmo_nx_s == TIMEOUT_V) begin
          id_nx_s       = ID_ZERO;
          id_err_nx_s   = 1'b1;
          rgb_oe_nx_s   = 1'b1;
          state_nx_s    = ERROR;
        end else begin
          state_nx_s    = SAMPLE;
        end
      end
      DONE, ERROR: begin
        if (bus.rd_req) begin
          cnt_nx_s      = CNT_ZERO;
          tmo_nx_s      = TMO_ZERO;
          stab_nx_s     = STAB_ZERO;
          prev_nx_s     = CAND_ZERO;
          id_nx_s       = ID_ZERO;
          id_valid_nx_s = 1'b0;
          id_err_nx_s   = 1'b0;
          rgb_oe_nx_s   = 1'b0;
          state_nx_s    = SETTLE;
        end else begin
          state_nx_s    = state_r;
        end
      end
      default: begin
        state_nx_s = SETTLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SETTLE;
      cnt_r      <= CNT_ZERO;
      tmo_r      <= TMO_ZERO;
      stab_r     <= STAB_ZERO;
      prev_r     <= CAND_ZERO;
      id_r       <= ID_ZERO;
      id_valid_r <= 1'b0;
      id_err_r   <= 1'b0;
      rgb_oe_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      tmo_r      <= tmo_nx_s;
      stab_r     <= stab_nx_s;
      prev_r     <= prev_nx_s;
      id_r       <= id_nx_s;
      id_valid_r <= id_valid_nx_s;
      id_err_r   <= id_err_nx_s;
      rgb_oe_r   <= rgb_oe_nx_s;
    end
  end

  assign bus.id       = id_r;
  assign bus.id_valid = id_valid_r;
  assign bus.id_err   = id_err_r;
  assign bus.rgb_oe   = rgb_oe_r;

`ifdef LCD_ID_DECODE_EN
  logic [RES_W-1:0] dec_h_s, dec_v_s;
  logic [RES_W-1:0] h_res_r, v_res_r;

  lcd_id_decode u_decode (
    .code  (cand_ext_s[2:0]),
    .h_res (dec_h_s),
    .v_res (dec_v_s)
  );

  // Resolution registers: load with the id latch, clear on re-probe.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_res_r <= RES_NONE;
      v_res_r <= RES_NONE;
    end else if ((state_r == SAMPLE) && (state_nx_s == DONE)) begin
      h_res_r <= dec_h_s;
      v_res_r <= dec_v_s;
    end else if (state_nx_s == SETTLE) begin
      h_res_r <= RES_NONE;
      v_res_r <= RES_NONE;
    end else begin
      h_res_r <= h_res_r;
      v_res_r <= v_res_r;
    end
  end

  assign bus.h_res = h_res_r;
  assign bus.v_res = v_res_r;
`else
  assign bus.h_res = RES_NONE;
  assign bus.v_res = RES_NONE;
`endif

endmodule
